serial_tx_queue: RTL and testbench

Parametrised successor to the calculator's serial transmit path. It buffers up to DEPTH result frames in an internal FIFO and serialises them LANES bits at a time on rising edges of the divided transmit clock. It supports MSB- or LSB-first ordering, single-frame or burst transmission, and a sticky overflow flag. It sits between the result/memory output mux and the DataOut pins, fed by the controller's sample and start-transmit strobes.

---
 rtl/serial_tx_queue.sv | 161 ++++++++++++++++
 tb/tb_serial_tx_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_queue.sv
// serial_tx_queue: frame FIFO feeding a LANES-wide serialiser
// clocked by rising edges of the divided transmit clock.
module serial_tx_queue #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       sample,
  input  logic                       startTx,
  input  logic                       burst,
  input  logic                       clkTx,
  input  logic                       clrOvf,
  output logic [LANES-1:0]           dout,
  output logic                       txBusy,
  output logic                       txDone,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BEATS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [LANES-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clk_tx_q, clk_tx_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic tick;
  logic pop;
  logic push_ok;

  always_comb begin
    clk_tx_d = clkTx;
    tick     = clkTx & ~clk_tx_q;
    pop      = (state_q == LOAD);
    // a full FIFO still takes a push when the head leaves this cycle
    push_ok  = sample & (~full_q | pop);

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);

    ovf_d = ovf_q;
    if (clrOvf) ovf_d = 1'b0;
    if (sample & ~push_ok) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    beat_d  = beat_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startTx & ~empty_q) state_d = LOAD;
      end
      LOAD: begin
        shreg_d = mem_q[rd_ptr_q];
        beat_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (beat_q == BW'(BEATS)) begin
            dout_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            busy_d = 1'b1;
            beat_d = beat_q + BW'(1);
            if (MSB_FIRST) begin
              dout_d  = shreg_q[WIDTH-1 -: LANES];
              shreg_d = shreg_q << LANES;
            end else begin
              dout_d  = shreg_q[LANES-1:0];
              shreg_d = shreg_q >> LANES;
            end
          end
        end
      end
      DONE: begin
        state_d = (burst & ~empty_q) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      shreg_q  <= '0;
      beat_q   <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clk_tx_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      shreg_q  <= shreg_d;
      beat_q   <= beat_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clk_tx_q <= clk_tx_d;
    end
  end

  assign dout     = dout_q;
  assign txBusy   = busy_q;
  assign txDone   = done_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_tx_queue.sv
// tb_serial_tx_queue: two instances (MSB- and LSB-first) on shared
// stimulus, checked against a frame-queue model.
module tb_serial_tx_queue;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam int NB = W / L;
  localparam int TXP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample = 1'b0;
  logic start_tx = 1'b0;
  logic burst = 1'b0;
  logic clk_tx = 1'b0;
  logic clr_ovf = 1'b0;
  logic [W-1:0] din = '0;

  logic [L-1:0]  dout0, dout1;
  logic          busy0, busy1, done0, done1;
  logic          full0, full1, empty0, empty1;
  logic          ovf0, ovf1;
  logic [CW-1:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;
  int model_q[$];
  bit model_ovf = 0;
  int t;

  int  sl0[$];
  int  sl1[$];
  int  done_n = 0;
  int  busy_cyc = 0;
  bit  cap_en = 0;
  logic tick_seen = 1'b0;
  logic prev_tx = 1'b0;

  always #5 clk = ~clk;
  always #20 clk_tx = ~clk_tx;

  serial_tx_queue #(.WIDTH(W), .LANES(L), .DEPTH(D), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(rst_n), .din(din), .sample(sample),
    .startTx(start_tx), .burst(burst), .clkTx(clk_tx), .clrOvf(clr_ovf),
    .dout(dout0), .txBusy(busy0), .txDone(done0), .full(full0),
    .empty(empty0), .count(cnt0), .overflow(ovf0)
  );

  serial_tx_queue #(.WIDTH(W), .LANES(L), .DEPTH(D), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(rst_n), .din(din), .sample(sample),
    .startTx(start_tx), .burst(burst), .clkTx(clk_tx), .clrOvf(clr_ovf),
    .dout(dout1), .txBusy(busy1), .txDone(done1), .full(full1),
    .empty(empty1), .count(cnt1), .overflow(ovf1)
  );

  always @(posedge clk) begin
    tick_seen <= clk_tx & ~prev_tx;
    prev_tx   <= clk_tx;
  end

  always @(negedge clk) begin
    if (cap_en) begin
      if (tick_seen && busy0) sl0.push_back(int'(dout0));
      if (tick_seen && busy1) sl1.push_back(int'(dout1));
      if (done0) done_n <= done_n + 1;
      if (busy0) busy_cyc <= busy_cyc + 1;
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(cnt0), model_q.size());
    chk({tag, "_count_lsb"}, 32'(cnt1), model_q.size());
    chk({tag, "_full"}, 32'(full0), 32'(model_q.size() == D));
    chk({tag, "_empty"}, 32'(empty0), 32'(model_q.size() == 0));
    chk({tag, "_ovf"}, 32'(ovf0), 32'(model_ovf));
  endtask

  // caller is aligned to a negedge; back-to-back calls give back-to-back pushes
  task automatic push(input logic [W-1:0] v);
    din = v;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    if (model_q.size() < D) model_q.push_back(int'(v));
    else model_ovf = 1;
  endtask

  task automatic clr();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    model_ovf = 0;
  endtask

  task automatic transmit(input bit b, input bit retrig);
    int exp_f[$];
    int b0, b1, d0, c0, tt;
    bit fired;
    if (model_q.size() > 0) begin
      if (b) begin
        exp_f = model_q;
        model_q.delete();
      end else begin
        exp_f.push_back(model_q.pop_front());
      end
    end
    burst = b;
    b0 = sl0.size();
    b1 = sl1.size();
    d0 = done_n;
    c0 = busy_cyc;
    cap_en = 1;
    start_tx = 1'b1;
    @(negedge clk);
    start_tx = 1'b0;
    tt = 0;
    fired = 0;
    while (done_n - d0 < exp_f.size() && tt < 80 * D) begin
      if (retrig && !fired && sl0.size() - b0 >= 2) begin
        start_tx = 1'b1;
        fired = 1;
      end
      @(negedge clk);
      start_tx = 1'b0;
      tt++;
    end
    repeat (40) @(negedge clk);
    cap_en = 0;
    chk("tx_done_pulses", done_n - d0, exp_f.size());
    chk("tx_busy_cycles", busy_cyc - c0, NB * TXP * exp_f.size());
    chk("tx_slices_msb", sl0.size() - b0, NB * exp_f.size());
    chk("tx_slices_lsb", sl1.size() - b1, NB * exp_f.size());
    for (int i = 0; i < exp_f.size(); i++) begin
      if (sl0.size() >= b0 + NB * (i + 1) && sl1.size() >= b1 + NB * (i + 1)) begin
        int m, l;
        m = 0;
        l = 0;
        for (int k = 0; k < NB; k++) begin
          m = (m << L) | sl0[b0 + NB * i + k];
          l = l | (sl1[b1 + NB * i + k] << (L * k));
        end
        chk("frame_msb", m, exp_f[i]);
        chk("frame_lsb", l, exp_f[i]);
      end
    end
    chk("idle_dout", 32'(dout0), 0);
    chk("idle_busy", 32'(busy0), 0);
  endtask

  initial begin
    int base, nb;
    int exp_m[4] = '{2, 3, 1, 0};
    int exp_l[4] = '{0, 1, 3, 2};

    @(negedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_full", 32'(full0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame, both orderings
    base = sl0.size();
    nb = sl1.size();
    push(8'hB4);
    chk_status("push1");
    transmit(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (sl0.size() > base + k && sl1.size() > nb + k) begin
        chk("b4_msb_slice", sl0[base + k], exp_m[k]);
        chk("b4_lsb_slice", sl1[nb + k], exp_l[k]);
      end
    end
    chk_status("basic_end");

    // overflow
    for (int v = 1; v <= 5; v++) begin
      push(W'(v));
      if (v == 4) begin
        chk("ovf_full4", 32'(full0), 1);
        chk("ovf_count4", 32'(cnt0), 4);
        chk("ovf_flag4", 32'(ovf0), 0);
      end
    end
    chk_status("ovf_after5");
    clr();
    chk_status("ovf_cleared");
    transmit(1'b1, 1'b0);
    chk_status("ovf_drained");

    // set wins over clear in the same cycle
    for (int v = 0; v < 4; v++) push(W'(8'h30 + v));
    din = 8'h77;
    sample = 1'b1;
    clr_ovf = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    clr_ovf = 1'b0;
    model_ovf = 1;
    chk_status("ovf_prio");
    clr();
    chk_status("ovf_prio_clr");
    transmit(1'b1, 1'b0);

    // burst
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    transmit(1'b1, 1'b0);
    chk_status("burst_end");

    // single mode with an ignored mid-frame request
    push(8'h5C);
    push(8'hE7);
    transmit(1'b0, 1'b1);
    chk_status("single_end");
    transmit(1'b0, 1'b0);
    chk_status("single_drain");

    // randomized traffic
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) push(W'($urandom_range(0, 255)));
      chk_status("rnd_push");
      if (model_ovf) begin
        clr();
        chk_status("rnd_clr");
      end
      transmit(1'($urandom_range(0, 1)), 1'b0);
      chk_status("rnd_tx");
    end
    transmit(1'b1, 1'b0);
    chk_status("rnd_drain");

    // asynchronous reset in the middle of a frame
    push(8'h5A);
    push(8'hC3);
    push(8'h96);
    burst = 1'b0;
    base = sl0.size();
    cap_en = 1;
    start_tx = 1'b1;
    @(negedge clk);
    start_tx = 1'b0;
    t = 0;
    while (sl0.size() - base < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("pre_rst_count", 32'(cnt0), 2);
    chk("pre_rst_busy", 32'(busy0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(dout0), 0);
    chk("async_rst_busy", 32'(busy0), 0);
    chk("async_rst_count", 32'(cnt0), 0);
    chk("async_rst_empty", 32'(empty0), 1);
    chk("async_rst_full", 32'(full0), 0);
    chk("async_rst_dout_lsb", 32'(dout1), 0);
    cap_en = 0;
    model_q.delete();
    model_ovf = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    transmit(1'b0, 1'b0);
    chk_status("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
